symm_upd: RTL and testbench

Final update stage of the symmetric-decorrelation iteration. It receives the 1.5·W matrix produced by the scale stage, the matching W·Wᵀ·W product and the previous W, one 4-element row per handshake. For each row it computes W_new = 1.5·W − ½·(W·Wᵀ·W) and streams the row back to the weight register file. After the fourth row it reports whether the largest element change is within tolerance, which drives the outer FastICA convergence loop.

---
 rtl/symm_pkg.sv | 29 ++
 rtl/symm_upd_lane.sv | 35 +++
 rtl/symm_upd.sv | 125 ++++++++++++
 tb/tb_symm_upd.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/symm_pkg.sv
// symm_pkg: definitions shared by the symmetric-decorrelation stages.
//   DW        element width (signed fixed point, same format as W)
//   NROW/NCOL matrix dimensions
//   elem_t    one matrix element
//   wide_t    one-bit-wider intermediate for add/sub results
//   sat_dw    clamps a wide_t result into the elem_t range
//   state_t   update-stage FSM states
package symm_pkg;

    localparam int DW   = 26;
    localparam int NROW = 4;
    localparam int NCOL = 4;

    typedef logic signed [DW-1:0] elem_t;
    typedef logic signed [DW:0]   wide_t;

    localparam elem_t ELEM_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam elem_t ELEM_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic {ST_RUN, ST_REPORT} state_t;

    // The top two bits disagree exactly when the value does not fit in DW bits.
    function automatic elem_t sat_dw(input wide_t x);
        if (x[DW] != x[DW-1])
            return x[DW] ? ELEM_MIN : ELEM_MAX;
        return x[DW-1:0];
    endfunction

endpackage

// File: rtl/symm_upd_lane.sv
// symm_upd_lane: one element of the W update, purely combinational.
//   a  in  row element of 1.5*W
//   p  in  row element of W*W'*W
//   w  in  row element of the previous W
//   n  out new element a - (p >>> 1), reduced to DW bits
//   d  out |n - w| as a DW+1 bit unsigned magnitude
// Build option: SYMM_UPD_SAT_EN clamps n on overflow; otherwise n wraps.
module symm_upd_lane
    import symm_pkg::*;
(
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] p,
    input  logic signed [DW-1:0] w,
    output logic signed [DW-1:0] n,
    output logic        [DW:0]   d
);

    wide_t diff;

`ifdef SYMM_UPD_SAT_EN
    wide_t n_full;
    // Arithmetic shift floors, so -3 >>> 1 is -2.
    assign n_full = wide_t'(a) - wide_t'(p >>> 1);
    assign n      = sat_dw(n_full);
`else
    // Wrapping build: DW-bit arithmetic already yields the low DW bits.
    assign n      = a - (p >>> 1);
`endif

    // The delta is taken on the reduced n, so a wrapped/clamped result
    // shows up as a large change and blocks convergence.
    assign diff = wide_t'(n) - wide_t'(w);
    assign d    = diff[DW] ? -diff : diff;

endmodule

// File: rtl/symm_upd.sv
// symm_upd: final update stage, W_new = 1.5*W - 0.5*(W*W'*W), one row per beat.
//   clk_upd, rst_upd            clock, synchronous active-high reset
//   in_valid/in_ready           input row handshake
//   ia0..3, ip0..3, iw0..3      rows of 1.5*W, W*W'*W, previous W
//   out_valid/out_ready         output row handshake
//   ow0..3, orow                new W row and its row index
//   done, converged             one-cycle end-of-matrix report; converged
//                               is set when max |W_new - W_old| <= TOL
// Build option: SYMM_UPD_SAT_EN selects saturation instead of wrap.
module symm_upd
    import symm_pkg::*;
#(
    parameter logic signed [DW-1:0] TOL = 26'sd16
)(
    input  logic                 clk_upd,
    input  logic                 rst_upd,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] ia0,
    input  logic signed [DW-1:0] ia1,
    input  logic signed [DW-1:0] ia2,
    input  logic signed [DW-1:0] ia3,
    input  logic signed [DW-1:0] ip0,
    input  logic signed [DW-1:0] ip1,
    input  logic signed [DW-1:0] ip2,
    input  logic signed [DW-1:0] ip3,
    input  logic signed [DW-1:0] iw0,
    input  logic signed [DW-1:0] iw1,
    input  logic signed [DW-1:0] iw2,
    input  logic signed [DW-1:0] iw3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] ow0,
    output logic signed [DW-1:0] ow1,
    output logic signed [DW-1:0] ow2,
    output logic signed [DW-1:0] ow3,
    output logic [1:0]           orow,
    output logic                 done,
    output logic                 converged
);

    logic [NCOL-1:0][DW-1:0] a_v, p_v, w_v, n_v, ow_q;
    logic [NCOL-1:0][DW:0]   d_v;
    logic [DW:0]             row_dmax, max_d;
    logic [1:0]              row;
    logic                    in_fire, out_fire, last_out;
    state_t                  state, state_nx;

    assign a_v = {ia3, ia2, ia1, ia0};
    assign p_v = {ip3, ip2, ip1, ip0};
    assign w_v = {iw3, iw2, iw1, iw0};

    for (genvar i = 0; i < NCOL; i++) begin : g_lane
        symm_upd_lane u_lane (
            .a (a_v[i]),
            .p (p_v[i]),
            .w (w_v[i]),
            .n (n_v[i]),
            .d (d_v[i])
        );
    end

    always_comb begin
        row_dmax = '0;
        for (int i = 0; i < NCOL; i++)
            if (d_v[i] > row_dmax) row_dmax = d_v[i];
    end

    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign last_out = out_fire && (orow == 2'd3);

    assign ow0 = ow_q[0];
    assign ow1 = ow_q[1];
    assign ow2 = ow_q[2];
    assign ow3 = ow_q[3];

    always_ff @(posedge clk_upd) begin
        if (rst_upd) state <= ST_RUN;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:    if (last_out) state_nx = ST_REPORT;
            ST_REPORT: state_nx = ST_RUN;
            default:   state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_upd) begin
        if (rst_upd) begin
            ow_q      <= '0;
            orow      <= '0;
            out_valid <= 1'b0;
            row       <= '0;
            max_d     <= '0;
            done      <= 1'b0;
            converged <= 1'b0;
        end else begin
            // max_d already holds row 3 when its output handshake happens.
            done      <= last_out;
            converged <= last_out && (max_d <= {1'b0, TOL});
            if (in_fire) begin
                ow_q      <= n_v;
                orow      <= row;
                row       <= row + 2'd1;
                out_valid <= 1'b1;
                // Row 0 of the next matrix can be accepted on the same edge
                // as the row-3 output handshake, so it restarts the max
                // instead of folding into the previous matrix.
                if (row == 2'd0 || row_dmax > max_d)
                    max_d <= row_dmax;
            end else begin
                if (out_fire)
                    out_valid <= 1'b0;
                if (state == ST_REPORT && row == 2'd0)
                    max_d <= '0;
            end
        end
    end

endmodule

// File: tb/tb_symm_upd.sv
module tb_symm_upd;

    localparam longint M    = longint'(1) << 26;
    localparam longint LMAX = (longint'(1) << 25) - 1;
    localparam longint LMIN = -(longint'(1) << 25);

    typedef struct packed {
        logic [3:0][25:0] n;
        logic [1:0]       r;
    } row_t;

    logic               clk_upd = 1'b0;
    logic               rst_upd = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [25:0] ia [4];
    logic signed [25:0] ip [4];
    logic signed [25:0] iw [4];
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [25:0] ow [4];
    logic [1:0]         orow;
    logic               done, converged;

    symm_upd dut (
        .clk_upd(clk_upd), .rst_upd(rst_upd),
        .in_valid(in_valid), .in_ready(in_ready),
        .ia0(ia[0]), .ia1(ia[1]), .ia2(ia[2]), .ia3(ia[3]),
        .ip0(ip[0]), .ip1(ip[1]), .ip2(ip[2]), .ip3(ip[3]),
        .iw0(iw[0]), .iw1(iw[1]), .iw2(iw[2]), .iw3(iw[3]),
        .out_valid(out_valid), .out_ready(out_ready),
        .ow0(ow[0]), .ow1(ow[1]), .ow2(ow[2]), .ow3(ow[3]),
        .orow(orow), .done(done), .converged(converged)
    );

    always #5 clk_upd = ~clk_upd;

    row_t   exp_q [$];
    bit     cvg_q [$];
    int     n_vec = 0, n_err = 0;
    int     cyc = 0, bp_until = 0;
    bit     rand_bp = 1'b0;
    int     mrow = 0;
    longint mmax = 0;

    // Downstream ready: forced low until bp_until, optionally randomised.
    always @(posedge clk_upd) begin
        cyc++;
        #1 out_ready = (cyc >= bp_until) && (!rand_bp || ($urandom % 4 != 0));
    end

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // ---------------- reference model ----------------
    function automatic longint sx(input longint x);
        longint y = x & (M - 1);
        if (y > LMAX) y -= M;
        return y;
    endfunction

    function automatic longint floor_half(input longint x);
        return (x >= 0) ? x / 2 : -((-x + 1) / 2);
    endfunction

    function automatic longint red(input longint x);
`ifdef SYMM_UPD_SAT_EN
        if (x > LMAX) return LMAX;
        if (x < LMIN) return LMIN;
        return x;
`else
        return sx(x);
`endif
    endfunction

    task automatic model_row(input longint a [4], input longint p [4], input longint w [4]);
        row_t   e;
        longint n, d;
        for (int i = 0; i < 4; i++) begin
            n      = red(a[i] - floor_half(p[i]));
            e.n[i] = n[25:0];
            d      = (n > w[i]) ? n - w[i] : w[i] - n;
            if (d > mmax) mmax = d;
        end
        e.r = mrow[1:0];
        exp_q.push_back(e);
        if (mrow == 3) begin
            cvg_q.push_back(mmax <= 16);
            mmax = 0;
        end
        mrow = (mrow + 1) % 4;
    endtask

    // ---------------- driver ----------------
    task automatic send_row(input longint a [4], input longint p [4], input longint w [4]);
        bit acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ia[i] = a[i][25:0];
            ip[i] = p[i][25:0];
            iw[i] = w[i][25:0];
        end
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk_upd);
            if (in_ready === 1'b1) acc = 1'b1;
            @(posedge clk_upd);
        end
        if (acc) model_row(a, p, w);
        else     fail_now("in_handshake");
        #1 in_valid = 1'b0;
    endtask

    task automatic send_uni(input longint a, input longint p, input longint w);
        longint av [4], pv [4], wv [4];
        for (int i = 0; i < 4; i++) begin
            av[i] = a; pv[i] = p; wv[i] = w;
        end
        send_row(av, pv, wv);
    endtask

    task automatic check_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_orow", orow, 0);
        chk("rst_done", done, 0);
        chk("rst_converged", converged, 0);
        chk("rst_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) chk("rst_ow", ow[i], 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit               pend_done = 1'b0, prev_stall = 1'b0, exp_c = 1'b0;
    logic signed [25:0] prev_ow [4];
    logic [1:0]       prev_orow;

    always @(negedge clk_upd) begin
        row_t e;
        if (rst_upd) begin
            pend_done  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (pend_done) begin
                chk("done", done, 1);
                chk("converged", converged, exp_c);
                chk("in_ready_report", in_ready, 0);
                pend_done = 1'b0;
            end else if (done !== 1'b0) begin
                chk("spurious_done", done, 0);
            end
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_orow", orow, prev_orow);
                for (int i = 0; i < 4; i++) chk("hold_ow", ow[i], prev_ow[i]);
            end
            if (out_valid === 1'b1 && out_ready === 1'b0)
                chk("in_ready_stall", in_ready, 0);
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_orow  = orow;
            for (int i = 0; i < 4; i++) prev_ow[i] = ow[i];
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_row");
                end else begin
                    e = exp_q.pop_front();
                    chk("orow", orow, e.r);
                    for (int i = 0; i < 4; i++) chk("ow", ow[i], $signed(e.n[i]));
                    if (e.r == 2'd3) begin
                        if (cvg_q.size() == 0) fail_now("converged_queue");
                        else begin
                            exp_c     = cvg_q.pop_front();
                            pend_done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        longint av [4], pv [4], wv [4];
        longint off;
        bit     got;
        int     mode;
        for (int i = 0; i < 4; i++) begin
            ia[i] = '0; ip[i] = '0; iw[i] = '0;
        end

        repeat (3) @(posedge clk_upd);
        @(negedge clk_upd);
        check_reset();
        @(posedge clk_upd);
        #1 rst_upd = 1'b0;

        // basic rows, expect 200 and convergence
        repeat (4) send_uni(300, 200, 200);
        // floor of negative shift: 10 - (-2) = 12
        repeat (4) send_uni(10, -3, 12);
        // overflow: clamps or wraps depending on build
        repeat (4) send_uni(33554431, -4, red(33554431 + 2));

        // one delta of 17 in row 2 -> not converged
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                av[i] = 1000; pv[i] = 0; wv[i] = 1000;
            end
            if (r == 2) wv[1] = 983;
            send_row(av, pv, wv);
        end
        // deltas up to exactly 16 -> converged (max_d must have cleared)
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                av[i] = -500; pv[i] = 0; wv[i] = (r == 1 && i == 3) ? -516 : -500;
            end
            send_row(av, pv, wv);
        end
        repeat (4) send_uni(7, 0, 7);

        // backpressure: hold row 1 for 3 cycles
        fork
            begin
                for (int r = 0; r < 4; r++) send_uni(100 * (r + 1), 0, 100 * (r + 1));
            end
            begin
                got = 1'b0;
                for (int k = 0; k < 100 && !got; k++) begin
                    @(negedge clk_upd);
                    if (out_valid === 1'b1 && orow == 2'd0) begin
                        bp_until = cyc + 4;
                        got = 1'b1;
                    end
                end
                if (!got) fail_now("bp_trigger");
            end
        join
        repeat (6) @(posedge clk_upd);

        // reset mid-matrix
        #1;
        send_uni(1, 0, 1);
        send_uni(2, 0, 2);
        repeat (3) @(posedge clk_upd);
        #1 rst_upd = 1'b1;
        exp_q.delete();
        cvg_q.delete();
        mrow = 0;
        mmax = 0;
        @(posedge clk_upd);
        @(negedge clk_upd);
        check_reset();
        @(posedge clk_upd);
        #1 rst_upd = 1'b0;
        for (int r = 0; r < 4; r++) send_uni(40 + r, 2, 39 + r);

        // randomised matrices with random stalls on both sides
        rand_bp = 1'b1;
        for (int m = 0; m < 24; m++) begin
            mode = $urandom % 3;
            for (int r = 0; r < 4; r++) begin
                for (int i = 0; i < 4; i++) begin
                    if (mode == 0) begin
                        av[i] = sx(longint'($urandom));
                        pv[i] = sx(longint'($urandom));
                        wv[i] = sx(longint'($urandom));
                    end else begin
                        av[i] = longint'($urandom_range(0, 1 << 24)) - (1 << 23);
                        pv[i] = longint'($urandom_range(0, 1 << 24)) - (1 << 23);
                        if ($urandom % 16 == 0) off = ($urandom % 2) ? 17 : -17;
                        else                    off = longint'($urandom_range(0, 32)) - 16;
                        wv[i] = red(av[i] - floor_half(pv[i])) + off;
                    end
                end
                send_row(av, pv, wv);
                repeat ($urandom % 3) @(posedge clk_upd);
                #1;
            end
        end
        rand_bp = 1'b0;

        for (int k = 0; k < 300 && exp_q.size() > 0; k++) @(posedge clk_upd);
        repeat (4) @(posedge clk_upd);
        chk("rows_outstanding", exp_q.size(), 0);
        chk("reports_outstanding", cvg_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
